// File: rtl/add3_pkg.sv
// Shared types and constants for the time-multiplexed 3-bit adder controller.
package add3_pkg;
  localparam int CHUNK_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ctrl_state_t;

  function automatic int nchunk(input int width);
    return width / CHUNK_W;
  endfunction
endpackage

// File: rtl/add3_slice.sv
// Combinational 3-bit adder slice with carry; a mapped netlist with the same ports can replace it.
module add3_slice (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {3'b000, cin};
endmodule

// File: rtl/add3_serial_ctrl.sv
// WIDTH-bit adder built from one 3-bit slice, walked LSB chunk first with a registered carry.
module add3_serial_ctrl
  import add3_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int NCHUNK = nchunk(WIDTH);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  if (WIDTH <= 0 || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
    $error("add3_serial_ctrl: WIDTH must be a positive multiple of 3");
  end

  ctrl_state_t      state, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cin_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CHUNK_W-1:0] a_chunk, b_chunk, s_chunk;
  logic               c_chunk;

  // Operands stay put; the counter picks the chunk, so no shifters are needed.
  assign a_chunk = a_q[int'(cnt_q)*CHUNK_W +: CHUNK_W];
  assign b_chunk = b_q[int'(cnt_q)*CHUNK_W +: CHUNK_W];

  add3_slice u_slice (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (cin_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)      state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cin_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          cin_q <= in_cin;
          sum_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          sum_q[int'(cnt_q)*CHUNK_W +: CHUNK_W] <= s_chunk;
          cin_q <= c_chunk;
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cin_q;
endmodule

// File: tb/tb_add3_serial_ctrl.sv
// Scoreboard bench: accepted operands push a+b+cin, the output monitor pops and compares.
module tb_add3_serial_ctrl;
  localparam int W  = 12;
  localparam int NC = W / 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [W-1:0]  in_a, in_b, out_sum;

  logic          w3_in_valid, w3_in_ready, w3_in_cin, w3_out_valid, w3_out_cout, w3_busy;
  logic [2:0]    w3_in_a, w3_in_b, w3_out_sum;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, acc_edge = 0, prev_acc = 0;
  bit b2b = 0, have_prev = 0;
  logic prev_ov = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add3_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  add3_serial_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(w3_in_valid), .in_ready(w3_in_ready),
    .in_a(w3_in_a), .in_b(w3_in_b), .in_cin(w3_in_cin), .out_valid(w3_out_valid),
    .out_ready(1'b1), .out_sum(w3_out_sum), .out_cout(w3_out_cout), .busy(w3_busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Acceptance observer: reference result is plain integer addition.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
      if (b2b && have_prev) chk("accept_spacing", 64'(cyc + 1 - prev_acc), 64'(NC + 2));
      prev_acc  = cyc + 1;
      have_prev = 1;
      acc_edge  = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) chk("latency", 64'(cyc - acc_edge), 64'(NC));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 64'(1), 64'(0));
        else chk("result", 64'({out_cout, out_sum}), 64'(sb.pop_front()));
      end
      prev_ov = out_valid;
    end else prev_ov = 1'b0;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
    int n = 0;
    logic r;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    do begin r = in_ready; step(); n++; end while (!r && n < 200);
    if (!r) chk("accept_timeout", 64'(0), 64'(1));
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    if (!out_valid) chk("valid_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [W:0] exp;
    logic [3:0] e3;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    w3_in_valid = 1'b0; w3_in_a = '0; w3_in_b = '0; w3_in_cin = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_cout", 64'(out_cout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    send(12'hFFF, 12'h001, 1'b0, 0); wait_valid(); step(); step();
    send(12'h000, 12'h000, 1'b1, 0); wait_valid(); step(); step();
    send(12'h5A5, 12'h2D2, 1'b0, 0); wait_valid(); step(); step();

    // Backpressure: hold the result while in_a wiggles.
    out_ready = 1'b0;
    exp = 13'h0AAA + 13'h0123 + 13'h1;
    send(12'hAAA, 12'h123, 1'b1, 0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = W'($urandom);
      step();
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_sum", 64'({out_cout, out_sum}), 64'(exp));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_ready_back", 64'(in_ready), 64'(1));
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Reset arrives while cnt==2.
    send(12'hFFF, 12'hFFF, 1'b1, 0);
    step(); step();
    rst_n = 1'b0;
    step();
    sb.delete();
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_sum", 64'(out_sum), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    send(12'h123, 12'h456, 1'b0, 0); wait_valid(); step(); step();

    // Back-to-back with in_valid and out_ready held high.
    have_prev = 0; b2b = 1;
    for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1);
    in_valid = 1'b0;
    b2b = 0;

    for (int i = 0; i < 1000; i++) begin
      n = $urandom_range(0, 3);
      if (n == 0)      send(W'(0), W'($urandom), 1'($urandom), 0);
      else if (n == 1) send('1, W'($urandom), 1'($urandom), 0);
      else             send(W'($urandom), W'($urandom), 1'($urandom), 0);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin step(); n++; end
    chk("final_drain", 64'(sb.size()), 64'(0));

    // Single-chunk instance.
    e3 = 4'd7 + 4'd7 + 4'd1;
    w3_in_a = 3'd7; w3_in_b = 3'd7; w3_in_cin = 1'b1; w3_in_valid = 1'b1;
    chk("w3_ready", 64'(w3_in_ready), 64'(1));
    step();
    w3_in_valid = 1'b0;
    chk("w3_run_no_valid", 64'(w3_out_valid), 64'(0));
    chk("w3_busy", 64'(w3_busy), 64'(1));
    step();
    chk("w3_valid", 64'(w3_out_valid), 64'(1));
    chk("w3_result", 64'({w3_out_cout, w3_out_sum}), 64'(e3));
    step();
    chk("w3_idle", 64'(w3_in_ready), 64'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
